prco_wb_arbiter: RTL and testbench
==================================

# prco_wb_arbiter

Write-back arbiter and register scoreboard for the `prco_regs` 8×16 register file. The register file has one write port. This block shares it between two producers: requester 0 is the ALU and requester 1 is the load/store unit. It uses round-robin arbitration with valid/ready handshakes and drives `i_we`/`i_seld`/`i_datd` of `prco_regs` from registered outputs. It also keeps a per-register busy scoreboard so the issue stage can stall on pending writes.

## Interface
- `NREG`, 8: number of architectural registers (scoreboard width)
- `AW`, 3: register select width
- `DW`, 16: data width
- `i_clk` in 1: clock, all state on rising edge
- `i_reset_n` in 1: asynchronous, active-low reset
- `i_en` in 1: global enable; low freezes all state, no grants
- `i_valid0` in 1: requester 0 (ALU) has a write pending
- `i_sel0` in AW: requester 0 destination register
- `i_dat0` in DW: requester 0 write data
- `o_ready0` out 1: requester 0 granted this cycle (handshake when valid & ready)
- `i_valid1`, `i_sel1`, `i_dat1`, `o_ready1`: same for requester 1 (LSU)
- `i_claim` in 1: issue stage marks a destination as pending
- `i_claim_sel` in AW: register being claimed
- `q_we` out 1: to `prco_regs` `i_we`
- `q_seld` out AW: to `prco_regs` `i_seld`
- `q_datd` out DW: to `prco_regs` `i_datd`
- `q_busy` out NREG: bit n set = register n has an outstanding write
- `q_last` out 1: index of the most recently granted requester

## Operation
- **Grant is combinational from the current inputs and the state.**
  - `o_ready0` = `i_en & i_valid0 & (!i_valid1 | prio==0)`
  - `o_ready1` = `i_en & i_valid1 & (!i_valid0 | prio==1)`
  - `prio` = `~q_last`. The non-last requester wins a tie.
  - At most one ready is high; ready never asserts without valid.
- **On a handshake at edge k:**
  - `q_we`←1, `q_seld`←sel of the winner, `q_datd`←dat of the winner, `q_last`←winner index.
  - If there is no handshake, `q_we`←0. `q_seld`/`q_datd` hold their last values.
- **Requester rule:** a requester holds valid/sel/dat stable until it sees ready. Dropping valid without a handshake is permitted; no write results.
- **Scoreboard:**
  - `i_claim & i_en` at an edge sets `q_busy[i_claim_sel]`.
  - An edge where `q_we`=1 (the `prco_regs` commit edge) clears `q_busy[q_seld]`.
- **Simultaneous claim and clear on the same register:** set wins (new producer outstanding).
- **Claim on an already-busy register:** stays 1. No count is kept; issue stage must not double-claim.
- **Same register requested by both producers in one cycle:** normal round-robin. The winner writes first and the loser writes on a later cycle (last writer wins in the register file).
- **`i_en`=0:**
  - No readies.
  - `q_we`←0 at the next edge.
  - `q_busy` and `q_last` hold.
  - A `q_we`=1 already on the outputs still commits and clears at that edge.
- Writes to any register (including r0) are treated identically.

## Timing
- **Reset (async assert, sync-to-edge release):**
  - `q_we`=0, `q_seld`=0, `q_datd`=0, `q_busy`=0, `q_last`=1 (so requester 0 has first priority).
  - `o_ready*`=0 while `i_reset_n`=0.
- **Handshake latency:**
  - Handshake at edge k → `q_we`=1 during cycle k..k+1.
  - Register file captures at edge k+1.
  - Busy bit clears at edge k+1; reads after k+1 see the new value.
- **Throughput:** one write per cycle. Back-to-back handshakes keep `q_we` high continuously.
- **Both valid continuously:** grants alternate 0,1,0,1…. Worst-case wait for a valid requester is 1 cycle.
- **Reset mid-operation:** pending output write is dropped (`q_we`→0 immediately) and the scoreboard is cleared. Requesters must re-present after release.

## Test plan
- **Reset/idle:** assert `i_reset_n`=0 mid-cycle → `q_we`=0, `q_busy`=8'h00, `q_datd`=0 immediately. Release with no valids → `o_ready0`=`o_ready1`=0.
- **Single write:** `i_valid0`=1, sel=1, dat=16'hf0f0 for one cycle → `o_ready0`=1. Next cycle `q_we`=1, `q_seld`=1, `q_datd`=16'hf0f0. With real `prco_regs` attached, `q_data` on `i_sela`=1 reads 16'hf0f0 two edges after the handshake.
- **Contention:** both valid continuously (sel0=2/dat 16'h1111, sel1=3/dat 16'h2222) for 4 cycles → grants 0,1,0,1. `q_seld` sequence 2,3,2,3 with `q_we` held high.
- **Scoreboard:**
  - Claim r5 at edge k → `q_busy`=8'h20.
  - Requester 1 writes r5 → bit clears on the commit edge, not the handshake edge.
  - Claim r5 on the same edge as the r5 commit → `q_busy[5]` stays 1.
- **Enable gating:** `i_en`=0 with both valid → no readies, `q_we`=0 after one edge, `q_busy`/`q_last` unchanged. Re-enable → the non-last requester is granted first.
- **Same-register race:** both target r4 (16'hAAAA from req0, 16'hBBBB from req1) with `q_last`=0 → req1 written first, then req0. r4 ends at 16'hAAAA.

Source files
------------

// File: rtl/prco_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prco_wb_arbiter
// Purpose  : Round-robin write-back arbiter (ALU / LSU) for prco_regs plus a
//            per-register pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module prco_wb_arbiter #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_en,
  input  logic            i_valid0,
  input  logic [AW-1:0]   i_sel0,
  input  logic [DW-1:0]   i_dat0,
  output logic            o_ready0,
  input  logic            i_valid1,
  input  logic [AW-1:0]   i_sel1,
  input  logic [DW-1:0]   i_dat1,
  output logic            o_ready1,
  input  logic            i_claim,
  input  logic [AW-1:0]   i_claim_sel,
  output logic            q_we,
  output logic [AW-1:0]   q_seld,
  output logic [DW-1:0]   q_datd,
  output logic [NREG-1:0] q_busy,
  output logic            q_last
);

  logic            r_we;
  logic [AW-1:0]   r_seld;
  logic [DW-1:0]   r_datd;
  logic [NREG-1:0] r_busy;
  logic            r_last;

  logic            w_hs0;
  logic            w_hs1;
  logic [NREG-1:0] w_busy_nxt;

  // The requester that did not win last time has priority on a tie.
  // Reset gating keeps both readies low while the block is held in reset.
  assign w_hs0 = i_reset_n & i_en & i_valid0 & (~i_valid1 | r_last);
  assign w_hs1 = i_reset_n & i_en & i_valid1 & (~i_valid0 | ~r_last);

  assign o_ready0 = w_hs0;
  assign o_ready1 = w_hs1;

  // Clear on commit first, then set on claim, so a same-edge claim wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int n = 0; n < NREG; n++) begin
      if (r_we && (r_seld == AW'(n)))
        w_busy_nxt[n] = 1'b0;
      if (i_en && i_claim && (i_claim_sel == AW'(n)))
        w_busy_nxt[n] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_we   <= 1'b0;
      r_seld <= '0;
      r_datd <= '0;
      r_busy <= '0;
      r_last <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_hs0) begin
        r_we   <= 1'b1;
        r_seld <= i_sel0;
        r_datd <= i_dat0;
        r_last <= 1'b0;
      end else if (w_hs1) begin
        r_we   <= 1'b1;
        r_seld <= i_sel1;
        r_datd <= i_dat1;
        r_last <= 1'b1;
      end else begin
        r_we   <= 1'b0;
      end
    end
  end

  assign q_we   = r_we;
  assign q_seld = r_seld;
  assign q_datd = r_datd;
  assign q_busy = r_busy;
  assign q_last = r_last;

endmodule
`default_nettype wire

// File: tb/tb_prco_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prco_wb_arbiter
// Purpose  : Directed self-checking bench for prco_wb_arbiter with a small
//            behavioural register file on the write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prco_wb_arbiter;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_en;
  logic        i_valid0;
  logic [2:0]  i_sel0;
  logic [15:0] i_dat0;
  logic        o_ready0;
  logic        i_valid1;
  logic [2:0]  i_sel1;
  logic [15:0] i_dat1;
  logic        o_ready1;
  logic        i_claim;
  logic [2:0]  i_claim_sel;
  logic        q_we;
  logic [2:0]  q_seld;
  logic [15:0] q_datd;
  logic [7:0]  q_busy;
  logic        q_last;

  int checks;
  int errors;

  logic [15:0] rf [8];

  prco_wb_arbiter #(.NREG(8), .AW(3), .DW(16)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
    .i_valid0(i_valid0), .i_sel0(i_sel0), .i_dat0(i_dat0), .o_ready0(o_ready0),
    .i_valid1(i_valid1), .i_sel1(i_sel1), .i_dat1(i_dat1), .o_ready1(o_ready1),
    .i_claim(i_claim), .i_claim_sel(i_claim_sel),
    .q_we(q_we), .q_seld(q_seld), .q_datd(q_datd), .q_busy(q_busy), .q_last(q_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural prco_regs write port.
  always @(posedge i_clk) if (q_we) rf[q_seld] <= q_datd;

  task automatic test_reset();
    i_reset_n = 1'b0; i_en = 1'b1; i_valid0 = 1'b1; i_valid1 = 1'b0;
    i_sel0 = 3'd0; i_dat0 = 16'h0; i_sel1 = 3'd0; i_dat1 = 16'h0;
    i_claim = 1'b0; i_claim_sel = 3'd0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (q_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", q_we); end
    checks++; if (q_seld !== 3'd0) begin errors++; $display("FAIL reset_seld got %0d exp 0", q_seld); end
    checks++; if (q_datd !== 16'h0) begin errors++; $display("FAIL reset_datd got %h exp 0000", q_datd); end
    checks++; if (q_busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", q_busy); end
    checks++; if (q_last !== 1'b1) begin errors++; $display("FAIL reset_last got %b exp 1", q_last); end
    checks++; if (o_ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b exp 0", o_ready0); end
    @(negedge i_clk);
    i_reset_n = 1'b1; i_valid0 = 1'b0;
    #1;
    checks++; if ({o_ready0, o_ready1} !== 2'b00) begin errors++; $display("FAIL idle_ready got %b exp 00", {o_ready0, o_ready1}); end
    @(posedge i_clk); #1;
    checks++; if (q_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b exp 0", q_we); end
  endtask

  task automatic test_contention();
    @(negedge i_clk);
    i_valid0 = 1'b1; i_sel0 = 3'd2; i_dat0 = 16'h1111;
    i_valid1 = 1'b1; i_sel1 = 3'd3; i_dat1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({o_ready0, o_ready1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL cont_grant[%0d] got %b exp %b", i, {o_ready0, o_ready1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(posedge i_clk); #1;
      checks++; if ({q_we, q_seld} !== {1'b1, (i % 2 == 0) ? 3'd2 : 3'd3}) begin
        errors++; $display("FAIL cont_write[%0d] got we=%b sel=%0d exp we=1 sel=%0d", i, q_we, q_seld, (i % 2 == 0) ? 2 : 3);
      end
      @(negedge i_clk);
    end
    i_valid0 = 1'b0; i_valid1 = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (q_we !== 1'b0) begin errors++; $display("FAIL cont_end_we got %b exp 0", q_we); end
    checks++; if (rf[3] !== 16'h2222) begin errors++; $display("FAIL cont_rf3 got %h exp 2222", rf[3]); end
  endtask

  task automatic test_single_write();
    @(negedge i_clk);
    i_valid0 = 1'b1; i_sel0 = 3'd1; i_dat0 = 16'hf0f0;
    #1;
    checks++; if ({o_ready0, o_ready1} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {o_ready0, o_ready1}); end
    @(posedge i_clk); #1;
    checks++; if ({q_we, q_seld, q_datd} !== {1'b1, 3'd1, 16'hf0f0}) begin
      errors++; $display("FAIL single_out got we=%b sel=%0d dat=%h exp we=1 sel=1 dat=f0f0", q_we, q_seld, q_datd);
    end
    checks++; if (q_last !== 1'b0) begin errors++; $display("FAIL single_last got %b exp 0", q_last); end
    @(negedge i_clk);
    i_valid0 = 1'b0;
    @(posedge i_clk); #1;
    checks++; if ({q_we, q_seld, q_datd} !== {1'b0, 3'd1, 16'hf0f0}) begin
      errors++; $display("FAIL single_hold got we=%b sel=%0d dat=%h exp we=0 sel=1 dat=f0f0", q_we, q_seld, q_datd);
    end
    checks++; if (rf[1] !== 16'hf0f0) begin errors++; $display("FAIL single_rf1 got %h exp f0f0", rf[1]); end
  endtask

  task automatic test_scoreboard();
    @(negedge i_clk);
    i_claim = 1'b1; i_claim_sel = 3'd5;
    @(posedge i_clk); #1;
    checks++; if (q_busy !== 8'h20) begin errors++; $display("FAIL sb_claim got %h exp 20", q_busy); end
    @(negedge i_clk);
    i_claim = 1'b0; i_valid1 = 1'b1; i_sel1 = 3'd5; i_dat1 = 16'h1234;
    @(posedge i_clk); #1;
    checks++; if (q_busy !== 8'h20) begin errors++; $display("FAIL sb_hs_edge got %h exp 20", q_busy); end
    @(negedge i_clk);
    i_valid1 = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (q_busy !== 8'h00) begin errors++; $display("FAIL sb_commit got %h exp 00", q_busy); end
    @(negedge i_clk);
    i_claim = 1'b1; i_claim_sel = 3'd5;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_claim = 1'b0; i_valid1 = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_valid1 = 1'b0; i_claim = 1'b1; i_claim_sel = 3'd5;
    @(posedge i_clk); #1;
    checks++; if (q_busy !== 8'h20) begin errors++; $display("FAIL sb_set_wins got %h exp 20", q_busy); end
    @(posedge i_clk); #1;
    checks++; if (q_busy !== 8'h20) begin errors++; $display("FAIL sb_double_claim got %h exp 20", q_busy); end
    @(negedge i_clk);
    i_claim = 1'b0;
  endtask

  task automatic test_enable();
    @(negedge i_clk);
    i_en = 1'b0; i_valid0 = 1'b1; i_valid1 = 1'b1;
    i_sel0 = 3'd6; i_dat0 = 16'h0606; i_sel1 = 3'd7; i_dat1 = 16'h0707;
    i_claim = 1'b1; i_claim_sel = 3'd2;
    #1;
    checks++; if ({o_ready0, o_ready1} !== 2'b00) begin errors++; $display("FAIL en_ready got %b exp 00", {o_ready0, o_ready1}); end
    repeat (2) @(posedge i_clk);
    #1;
    checks++; if (q_we !== 1'b0) begin errors++; $display("FAIL en_we got %b exp 0", q_we); end
    checks++; if ({q_busy, q_last} !== {8'h20, 1'b1}) begin
      errors++; $display("FAIL en_hold got busy=%h last=%b exp busy=20 last=1", q_busy, q_last);
    end
    @(negedge i_clk);
    i_en = 1'b1; i_claim = 1'b0;
    #1;
    checks++; if ({o_ready0, o_ready1} !== 2'b10) begin errors++; $display("FAIL en_resume got %b exp 10", {o_ready0, o_ready1}); end
    @(posedge i_clk); #1;
    checks++; if ({q_we, q_seld, q_last} !== {1'b1, 3'd6, 1'b0}) begin
      errors++; $display("FAIL en_first got we=%b sel=%0d last=%b exp we=1 sel=6 last=0", q_we, q_seld, q_last);
    end
    @(negedge i_clk);
    i_valid0 = 1'b0; i_valid1 = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_same_reg();
    @(negedge i_clk);
    i_valid0 = 1'b1; i_sel0 = 3'd4; i_dat0 = 16'hAAAA;
    i_valid1 = 1'b1; i_sel1 = 3'd4; i_dat1 = 16'hBBBB;
    #1;
    checks++; if ({o_ready0, o_ready1} !== 2'b01) begin errors++; $display("FAIL race_first got %b exp 01", {o_ready0, o_ready1}); end
    @(posedge i_clk); #1;
    checks++; if (q_datd !== 16'hBBBB) begin errors++; $display("FAIL race_dat1 got %h exp bbbb", q_datd); end
    @(negedge i_clk);
    i_valid1 = 1'b0;
    #1;
    checks++; if ({o_ready0, o_ready1} !== 2'b10) begin errors++; $display("FAIL race_second got %b exp 10", {o_ready0, o_ready1}); end
    @(posedge i_clk); #1;
    checks++; if (q_datd !== 16'hAAAA) begin errors++; $display("FAIL race_dat0 got %h exp aaaa", q_datd); end
    @(negedge i_clk);
    i_valid0 = 1'b0;
    @(posedge i_clk); #1;
    checks++; if (rf[4] !== 16'hAAAA) begin errors++; $display("FAIL race_rf4 got %h exp aaaa", rf[4]); end
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_valid0 = 1'b1; i_sel0 = 3'd6; i_dat0 = 16'h5555;
    i_claim = 1'b1; i_claim_sel = 3'd6;
    @(posedge i_clk); #1;
    checks++; if ({q_we, q_busy} !== {1'b1, 8'h60}) begin
      errors++; $display("FAIL mid_pre got we=%b busy=%h exp we=1 busy=60", q_we, q_busy);
    end
    #2;
    i_reset_n = 1'b0;
    #1;
    checks++; if ({q_we, q_busy, q_datd} !== {1'b0, 8'h00, 16'h0}) begin
      errors++; $display("FAIL mid_reset got we=%b busy=%h dat=%h exp we=0 busy=00 dat=0000", q_we, q_busy, q_datd);
    end
    checks++; if (o_ready0 !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", o_ready0); end
    @(negedge i_clk);
    i_valid0 = 1'b0; i_claim = 1'b0;
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int r = 0; r < 8; r++) rf[r] = 16'h0;
    test_reset();
    test_contention();
    test_single_write();
    test_scoreboard();
    test_enable();
    test_same_reg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
